// File: rtl/pixel_merger.sv
// Rasterizer pixel-write sink: round-robin capture slots, depth-tested framebuffer commit, clear engine.
// Optional depth test (read-compare-write) enabled by defining PIXEL_MERGER_DEPTH_TEST_EN.
module pixel_merger #(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned FB_WIDTH = 640,
    parameter int unsigned HEIGHT   = 480,
    parameter int unsigned ADDR_W   = 19,
    localparam int unsigned X_W     = 10,
    localparam int unsigned Y_W     = 9,
    localparam int unsigned CH_W    = 8,
    localparam int unsigned PIX_W   = 4 * CH_W,
    localparam int unsigned INFO_W  = X_W + Y_W + PIX_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC*INFO_W-1:0] data_in,
    input  logic [N_SRC-1:0]        data_write,
    output logic [N_SRC-1:0]        output_written,
    input  logic                    clear_start,
    input  logic [PIX_W-1:0]        bg_pixel,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic                    fb_rd_en,
    input  logic [PIX_W-1:0]        fb_rd_data,
    output logic                    fb_wr_en,
    output logic [PIX_W-1:0]        fb_wr_data,
    output logic                    busy,
    output logic [15:0]             drop_count
);

    typedef struct packed {
        logic [CH_W-1:0] red;
        logic [CH_W-1:0] green;
        logic [CH_W-1:0] blue;
        logic [CH_W-1:0] depth;
    } pixel_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        pixel_t         pixel;
    } pixel_info_t;

    localparam int unsigned IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned FB_WORDS = FB_WIDTH * HEIGHT;

    localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
    localparam logic [1:0] S_READ  = 2'd1;
`endif
    localparam logic [1:0] S_CMP   = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              clear_pend_q, clear_pend_d;
    logic [N_SRC-1:0]  slot_full_q, slot_full_d;
    pixel_t            slot_pix_q [N_SRC];
    pixel_t            slot_pix_d [N_SRC];
    logic [ADDR_W-1:0] slot_addr_q [N_SRC];
    logic [ADDR_W-1:0] slot_addr_d [N_SRC];
    logic [N_SRC-1:0]  output_written_q, output_written_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_rd_en_q, fb_rd_en_d;
    logic              fb_wr_en_q, fb_wr_en_d;
    logic [PIX_W-1:0]  fb_wr_data_q, fb_wr_data_d;
    logic              busy_q, busy_d;
    logic [15:0]       drop_count_q, drop_count_d;

    pixel_info_t       pin;
    pixel_t            cur;
    logic [3:0]        n_drop;
    logic [16:0]       drop_sum;
    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              rd_data_unused;

    // Only the depth byte of the read word takes part in the compare.
    assign rd_data_unused = ^fb_rd_data;

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        win_d            = win_q;
        clear_pend_d     = clear_pend_q | (clear_start && (state_q != S_CLEAR));
        slot_full_d      = slot_full_q;
        slot_pix_d       = slot_pix_q;
        slot_addr_d      = slot_addr_q;
        fb_addr_d        = fb_addr_q;
        fb_rd_en_d       = 1'b0;
        fb_wr_en_d       = 1'b0;
        fb_wr_data_d     = fb_wr_data_q;
        n_drop           = 4'd0;
        pin              = '0;
        found            = 1'b0;
        pick             = '0;
        cand             = '0;
        cur              = slot_pix_q[win_q];

        // Round-robin search: first full slot at or after the rr pointer.
        for (int k = 0; k < N_SRC; k++) begin
            cand = IDX_W'((32'(rr_q) + 32'(k)) % N_SRC);
            if (!found && slot_full_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        // Capture; the address multiply happens here so S_READ only muxes.
        for (int i = 0; i < N_SRC; i++) begin
            pin = data_in[i*INFO_W +: INFO_W];
            if (data_write[i]) begin
                if ((32'(pin.x) >= FB_WIDTH) || (32'(pin.y) >= HEIGHT)) begin
                    n_drop = n_drop + 4'd1;
                end else if (slot_full_q[i]) begin
                    n_drop = n_drop + 4'd1;
                end else begin
                    slot_full_d[i] = 1'b1;
                    slot_pix_d[i]  = pin.pixel;
                    slot_addr_d[i] = ADDR_W'(32'(pin.y) * FB_WIDTH + 32'(pin.x));
                end
            end
        end

        drop_sum     = 17'(drop_count_q) + 17'(n_drop);
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        case (state_q)
            S_IDLE: begin
                if (clear_pend_q) begin
                    state_d      = S_CLEAR;
                    clear_pend_d = 1'b0;
                    fb_addr_d    = '0;
                    fb_wr_en_d   = 1'b1;
                    fb_wr_data_d = bg_pixel;
                end else if (found) begin
                    win_d     = pick;
                    rr_d      = IDX_W'((32'(pick) + 32'd1) % N_SRC);
                    fb_addr_d = slot_addr_q[pick];
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
                    state_d    = S_READ;
                    fb_rd_en_d = 1'b1;
`else
                    state_d    = S_CMP;
`endif
                end
            end
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
            S_READ: begin
                state_d = S_CMP;
            end
`endif
            S_CMP: begin
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
                // Strictly nearer wins; equal depth keeps the earlier pixel.
                if (cur.depth < fb_rd_data[CH_W-1:0]) begin
                    fb_wr_en_d   = 1'b1;
                    fb_wr_data_d = cur;
                end
`else
                fb_wr_en_d   = 1'b1;
                fb_wr_data_d = cur;
`endif
                slot_full_d[win_q] = 1'b0;
                state_d            = S_IDLE;
            end
            S_CLEAR: begin
                if (fb_addr_q == ADDR_W'(FB_WORDS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    fb_addr_d    = fb_addr_q + ADDR_W'(1);
                    fb_wr_en_d   = 1'b1;
                    fb_wr_data_d = bg_pixel;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        output_written_d = ~slot_full_d;
        busy_d           = (state_d != S_IDLE) || (|slot_full_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            rr_q             <= '0;
            win_q            <= '0;
            clear_pend_q     <= 1'b0;
            slot_full_q      <= '0;
            output_written_q <= '1;
            fb_addr_q        <= '0;
            fb_rd_en_q       <= 1'b0;
            fb_wr_en_q       <= 1'b0;
            fb_wr_data_q     <= '0;
            busy_q           <= 1'b0;
            drop_count_q     <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_pix_q[i]  <= '0;
                slot_addr_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            rr_q             <= rr_d;
            win_q            <= win_d;
            clear_pend_q     <= clear_pend_d;
            slot_full_q      <= slot_full_d;
            output_written_q <= output_written_d;
            fb_addr_q        <= fb_addr_d;
            fb_rd_en_q       <= fb_rd_en_d;
            fb_wr_en_q       <= fb_wr_en_d;
            fb_wr_data_q     <= fb_wr_data_d;
            busy_q           <= busy_d;
            drop_count_q     <= drop_count_d;
            for (int i = 0; i < N_SRC; i++) begin
                slot_pix_q[i]  <= slot_pix_d[i];
                slot_addr_q[i] <= slot_addr_d[i];
            end
        end
    end

    assign output_written = output_written_q;
    assign fb_addr        = fb_addr_q;
    assign fb_rd_en       = fb_rd_en_q;
    assign fb_wr_en       = fb_wr_en_q;
    assign fb_wr_data     = fb_wr_data_q;
    assign busy           = busy_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_pixel_merger.sv
// Directed bench for pixel_merger with a registered-read framebuffer model (640 x 8 to keep the clear short).
`timescale 1ns/1ps
module tb_pixel_merger;

    localparam int N_SRC    = 4;
    localparam int FB_WIDTH = 640;
    localparam int HEIGHT   = 8;
    localparam int ADDR_W   = 19;
    localparam int INFO_W   = 51;
    localparam int FB_WORDS = FB_WIDTH * HEIGHT;
`ifdef PIXEL_MERGER_DEPTH_TEST_EN
    localparam bit DT  = 1'b1;
    localparam int LAT = 3;
`else
    localparam bit DT  = 1'b0;
    localparam int LAT = 2;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_SRC*INFO_W-1:0] data_in;
    logic [N_SRC-1:0]        data_write;
    logic [N_SRC-1:0]        output_written;
    logic                    clear_start;
    logic [31:0]             bg_pixel;
    logic [ADDR_W-1:0]       fb_addr;
    logic                    fb_rd_en;
    logic [31:0]             fb_rd_data = 32'd0;
    logic                    fb_wr_en;
    logic [31:0]             fb_wr_data;
    logic                    busy;
    logic [15:0]             drop_count;

    logic [31:0] mem [0:8191];
    int unsigned cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    int unsigned wl_addr[$];
    logic [31:0] wl_data[$];
    int unsigned wl_cyc[$];
    int          tests = 0, fails = 0;

    pixel_merger #(.N_SRC(N_SRC), .FB_WIDTH(FB_WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) dut (
        .clock(clk), .reset(reset), .data_in(data_in), .data_write(data_write),
        .output_written(output_written), .clear_start(clear_start), .bg_pixel(bg_pixel),
        .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data), .fb_wr_en(fb_wr_en),
        .fb_wr_data(fb_wr_data), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Framebuffer model: read data valid the cycle after fb_rd_en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fb_rd_en) begin
            fb_rd_data <= mem[fb_addr[12:0]];
            rd_cnt     <= rd_cnt + 1;
        end
        if (fb_wr_en) begin
            mem[fb_addr[12:0]] <= fb_wr_data;
            wl_addr.push_back(32'(fb_addr));
            wl_data.push_back(fb_wr_data);
            wl_cyc.push_back(cyc);
            wr_cnt <= wr_cnt + 1;
        end
        if (fb_rd_en && fb_wr_en) both_cnt <= both_cnt + 1;
    end

    function automatic logic [INFO_W-1:0] mk(input int x, input int y, input logic [31:0] pix);
        mk = {10'(x), 9'(y), pix};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int src, input logic [INFO_W-1:0] info);
        data_in[src*INFO_W +: INFO_W] = info;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; data_write = '0; data_in = '0; clear_start = 1'b0; bg_pixel = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h000000FF;
        repeat (3) step();
        tests++;
        if (output_written !== 4'hF) begin
            fails++; $display("FAIL reset_ow: got %h want f", output_written);
        end
        tests++;
        if ({fb_rd_en, fb_wr_en, busy, fb_addr, fb_wr_data, drop_count} !== '0) begin
            fails++;
            $display("FAIL reset_outs: rd=%b wr=%b busy=%b addr=%0d wdata=%h drop=%0d want all 0",
                     fb_rd_en, fb_wr_en, busy, fb_addr, fb_wr_data, drop_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic        ow0 [6];
        logic        rdv [6];
        logic        wrv [6];
        logic [18:0] av  [6];
        logic [31:0] dv  [6];
        put(0, mk(3, 2, 32'h1122330A));
        data_write = 4'b0001;
        step();
        data_write = '0;
        for (int c = 0; c < 6; c++) begin
            ow0[c] = output_written[0]; rdv[c] = fb_rd_en; wrv[c] = fb_wr_en;
            av[c] = fb_addr; dv[c] = fb_wr_data;
            step();
        end
        tests++;
        if (ow0[0] !== 1'b0) begin fails++; $display("FAIL single_capture_ow: got %b want 0", ow0[0]); end
        tests++;
        if (rdv[1] !== DT) begin fails++; $display("FAIL single_rd_en: got %b want %b", rdv[1], DT); end
        tests++;
        if (av[1] !== 19'd1283) begin fails++; $display("FAIL single_issue_addr: got %0d want 1283", av[1]); end
        tests++;
        if (wrv[LAT-1] !== 1'b0) begin fails++; $display("FAIL single_early_wr: got %b want 0", wrv[LAT-1]); end
        tests++;
        if ({wrv[LAT], av[LAT], dv[LAT]} !== {1'b1, 19'd1283, 32'h1122330A}) begin
            fails++; $display("FAIL single_write: wr=%b addr=%0d data=%h want 1/1283/1122330a", wrv[LAT], av[LAT], dv[LAT]);
        end
        tests++;
        if ({ow0[LAT-1], ow0[LAT]} !== 2'b01) begin
            fails++; $display("FAIL single_ow_release: got %b%b want 01", ow0[LAT-1], ow0[LAT]);
        end
    endtask

    task automatic test_reset_mid_op();
        int unsigned w0;
        w0 = wr_cnt;
        put(3, mk(4, 4, 32'h0000000B));
        data_write = 4'b1000;
        step();
        data_write = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        tests++;
        if ({wr_cnt == w0, output_written, busy} !== {1'b1, 4'hF, 1'b0}) begin
            fails++; $display("FAIL reset_mid_op: writes=%0d ow=%h busy=%b want 0/f/0", wr_cnt - w0, output_written, busy);
        end
    endtask

    task automatic test_depth();
        bit ok;
        int hits;
        int base;
        logic [31:0] pix [3];
        int src [3];
        pix[0] = 32'hAA000032; pix[1] = 32'hBB000050; pix[2] = 32'hCC000032;
        src[0] = 0; src[1] = 1; src[2] = 0;
        base = wl_addr.size();
        for (int n = 0; n < 3; n++) begin
            put(src[n], mk(5, 1, pix[n]));
            data_write = 4'(1 << src[n]);
            step();
            data_write = '0;
            wait_idle(20, ok);
            tests++;
            if (ok !== 1'b1) begin fails++; $display("FAIL depth_idle_%0d: busy stuck got %b want 1", n, ok); end
            hits = 0;
            for (int k = base; k < wl_addr.size(); k++) if (wl_addr[k] == 645) hits++;
            tests++;
            if (hits != (DT ? 1 : n + 1)) begin
                fails++; $display("FAIL depth_writes_%0d: got %0d want %0d", n, hits, DT ? 1 : n + 1);
            end
            tests++;
            if (mem[645] !== (DT ? pix[0] : pix[n])) begin
                fails++; $display("FAIL depth_mem_%0d: got %h want %h", n, mem[645], DT ? pix[0] : pix[n]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int base;
        int first [3];
        int xoff [3];
        int exp;
        do_reset();
        first[0] = 0; first[1] = 0; first[2] = 1;
        xoff[0] = 10; xoff[1] = 20; xoff[2] = 40;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) begin
                put(0, mk(30, 3, 32'h00000020));
                data_write = 4'b0001;
                step();
                data_write = '0;
                wait_idle(20, ok);
            end
            for (int s = 0; s < 4; s++) put(s, mk(xoff[b] + s, 3, 32'h00000020));
            base = wl_addr.size();
            data_write = 4'hF;
            step();
            data_write = '0;
            wait_idle(40, ok);
            tests++;
            if (ok !== 1'b1) begin fails++; $display("FAIL rr_idle_%0d: busy stuck got %b want 1", b, ok); end
            for (int k = 0; k < 4; k++) begin
                exp = 3 * FB_WIDTH + xoff[b] + (first[b] + k) % 4;
                tests++;
                if ((base + k >= wl_addr.size()) || (wl_addr[base+k] != exp)) begin
                    fails++;
                    $display("FAIL rr_order_b%0d_k%0d: got %0d want %0d", b, k,
                             (base + k < wl_addr.size()) ? wl_addr[base+k] : -1, exp);
                end
            end
            if (b == 0 && wl_cyc.size() >= base + 4) begin
                for (int k = 0; k < 3; k++) begin
                    tests++;
                    if (wl_cyc[base+k+1] - wl_cyc[base+k] != LAT) begin
                        fails++; $display("FAIL rr_spacing_%0d: got %0d want %0d", k, wl_cyc[base+k+1] - wl_cyc[base+k], LAT);
                    end
                end
            end
        end
    endtask

    task automatic test_drops();
        bit ok;
        int unsigned r0, w0;
        logic [15:0] d0;
        d0 = drop_count;
        put(2, mk(1, 1, 32'h00000040));
        data_write = 4'b0100;
        step();
        step();
        data_write = '0;
        tests++;
        if (drop_count !== d0 + 16'd1) begin fails++; $display("FAIL drop_full: got %0d want %0d", drop_count, d0 + 1); end
        wait_idle(20, ok);
        tests++;
        if ({ok, wl_addr[wl_addr.size()-1] == 641} !== 2'b11) begin
            fails++; $display("FAIL drop_first_kept: idle=%b last_addr=%0d want 1/641", ok, wl_addr[wl_addr.size()-1]);
        end
        r0 = rd_cnt; w0 = wr_cnt;
        put(1, mk(640, 0, 32'h00000001));
        data_write = 4'b0010;
        step();
        data_write = '0;
        tests++;
        if ({drop_count, output_written[1], busy} !== {d0 + 16'd2, 1'b1, 1'b0}) begin
            fails++; $display("FAIL drop_x_range: drop=%0d ow1=%b busy=%b want %0d/1/0", drop_count, output_written[1], busy, d0 + 2);
        end
        put(0, mk(640, 0, 32'h00000001));
        put(3, mk(0, 8, 32'h00000001));
        data_write = 4'b1001;
        step();
        data_write = '0;
        tests++;
        if (drop_count !== d0 + 16'd4) begin fails++; $display("FAIL drop_multi: got %0d want %0d", drop_count, d0 + 4); end
        repeat (5) step();
        tests++;
        if ({rd_cnt == r0, wr_cnt == w0} !== 2'b11) begin
            fails++; $display("FAIL drop_no_access: rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_cnt - w0);
        end
        put(0, mk(639, 7, 32'h0000000E));
        data_write = 4'b0001;
        step();
        data_write = '0;
        wait_idle(20, ok);
        tests++;
        if ({drop_count, wl_addr[wl_addr.size()-1] == 5119, mem[5119]} !== {d0 + 16'd4, 1'b1, 32'h0000000E}) begin
            fails++; $display("FAIL edge_pixel: drop=%0d addr=%0d mem=%h want %0d/5119/0000000e",
                              drop_count, wl_addr[wl_addr.size()-1], mem[5119], d0 + 4);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        logic [15:0] d0;
        d0 = drop_count;
        base = wl_addr.size();
        put(1, mk(7, 4, 32'h00000021));
        data_write = 4'b0010;
        step();
        data_write = '0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (output_written[1]) begin ok = 1'b1; break; end
            step();
        end
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL refill_release: got %b want 1", ok); end
        put(1, mk(8, 4, 32'h00000022));
        data_write = 4'b0010;
        step();
        data_write = '0;
        tests++;
        if ({output_written[1], drop_count} !== {1'b0, d0}) begin
            fails++; $display("FAIL refill_capture: ow1=%b drop=%0d want 0/%0d", output_written[1], drop_count, d0);
        end
        wait_idle(20, ok);
        tests++;
        if ((wl_addr.size() != base + 2) || (wl_addr[base] != 2567) || (wl_addr[base+1] != 2568)) begin
            fails++; $display("FAIL refill_writes: count=%0d want 2 at 2567,2568", wl_addr.size() - base);
        end
    endtask

    task automatic test_clear();
        bit ok;
        int unsigned w0;
        int bad, first_bad;
        bg_pixel = 32'h010203FF;
        w0 = wr_cnt;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fb_wr_en) begin ok = 1'b1; break; end
            step();
        end
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL clear_start_wr: got %b want 1", ok); end
        bad = 0; first_bad = -1;
        for (int k = 0; k < FB_WORDS; k++) begin
            if (!fb_wr_en || (fb_addr != 19'(k)) || (fb_wr_data != 32'h010203FF) || fb_rd_en) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            if (k == 10) begin put(1, mk(2, 0, 32'h44556605)); data_write = 4'b0010; end
            if (k == 11) data_write = '0;
            if (k == 100) clear_start = 1'b1;
            if (k == 101) clear_start = 1'b0;
            if (k == 50) begin
                tests++;
                if ({output_written[1], busy} !== 2'b01) begin
                    fails++; $display("FAIL clear_slot_hold: ow1=%b busy=%b want 0/1", output_written[1], busy);
                end
            end
            step();
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL clear_sweep: %0d bad words, first at %0d, want 0", bad, first_bad); end
        wait_idle(20, ok);
        tests++;
        if ({ok, wr_cnt - w0 == FB_WORDS + 1, mem[2]} !== {2'b11, 32'h44556605}) begin
            fails++; $display("FAIL clear_drain: idle=%b writes=%0d mem2=%h want 1/%0d/44556605",
                              ok, wr_cnt - w0, mem[2], FB_WORDS + 1);
        end
        repeat (10) step();
        tests++;
        if ({busy, wr_cnt - w0 == FB_WORDS + 1, mem[5119]} !== {2'b01, 32'h010203FF}) begin
            fails++; $display("FAIL clear_ignored_restart: busy=%b writes=%0d mem5119=%h want 0/%0d/010203ff",
                              busy, wr_cnt - w0, mem[5119], FB_WORDS + 1);
        end
    endtask

    task automatic test_no_depth();
        bit ok;
        int unsigned r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        put(2, mk(9, 5, 32'h12000032));
        data_write = 4'b0100;
        step();
        data_write = '0;
        wait_idle(20, ok);
        put(3, mk(9, 5, 32'h34000050));
        data_write = 4'b1000;
        step();
        data_write = '0;
        wait_idle(20, ok);
        tests++;
        if (rd_cnt - r0 != (DT ? 2 : 0)) begin fails++; $display("FAIL mode_reads: got %0d want %0d", rd_cnt - r0, DT ? 2 : 0); end
        tests++;
        if (wr_cnt - w0 != (DT ? 1 : 2)) begin fails++; $display("FAIL mode_writes: got %0d want %0d", wr_cnt - w0, DT ? 1 : 2); end
        tests++;
        if (mem[3209] !== (DT ? 32'h12000032 : 32'h34000050)) begin
            fails++; $display("FAIL mode_mem: got %h want %h", mem[3209], DT ? 32'h12000032 : 32'h34000050);
        end
    endtask

    task automatic test_exclusive_strobes();
        tests++;
        if (both_cnt != 0) begin fails++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_reset_mid_op();
        test_depth();
        test_round_robin();
        test_drops();
        test_back_to_back();
        test_clear();
        test_no_depth();
        test_exclusive_strobes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
